// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetch stage: holds the PC, issues level req/ack fetches to instruction
//   memory, latches the returned word and offers it downstream through a
//   valid/ready handshake. Redirects are taken only when the held
//   instruction is accepted. A fetch that stays unacknowledged for
//   TIMEOUT_CYCLES request cycles parks the unit in HALT with Fetch_Err_o set.
//   Optional build macro: IFU_MISALIGN_TRAP_EN (misaligned redirect traps
//   instead of being silently word-aligned).
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0040_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        IMEM_Req_o,
    output logic [31:0] IMEM_Addr_o,
    input  logic        IMEM_Ack_i,
    input  logic [31:0] IMEM_Data_i,
    output logic [31:0] Instr_o,
    output logic [6:0]  Opcode_o,
    output logic        Instr_Valid_o,
    input  logic        Instr_Ready_i,
    output logic [31:0] PC_o,
    output logic [31:0] PC_Plus_4_o,
    input  logic        Redirect_i,
    input  logic [31:0] Target_i,
    output logic        Fetch_Err_o,
    output logic        Trap_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam int unsigned CNT_W       = 16;
    localparam logic        TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
    // Count value seen in the last permitted unacknowledged FETCH cycle
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_reg, state_next;
    logic [31:0]        pc_reg, pc_next;
    logic [31:0]        instr_reg, instr_next;
    logic               valid_reg, valid_next;
    logic [CNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic               fetch_err_reg, fetch_err_next;
`ifdef IFU_MISALIGN_TRAP_EN
    logic               trap_reg, trap_next;
`endif

    logic               accept;

    assign accept = valid_reg & Instr_Ready_i;

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            pc_reg        <= RESET_PC;
            instr_reg     <= 32'h0;
            valid_reg     <= 1'b0;
            wait_cnt_reg  <= '0;
            fetch_err_reg <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
            trap_reg      <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            instr_reg     <= instr_next;
            valid_reg     <= valid_next;
            wait_cnt_reg  <= wait_cnt_next;
            fetch_err_reg <= fetch_err_next;
`ifdef IFU_MISALIGN_TRAP_EN
            trap_reg      <= trap_next;
`endif
        end
    end

    // Next-state logic: fetch, hold-until-accept, PC update, timeout
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        instr_next     = instr_reg;
        valid_next     = valid_reg;
        wait_cnt_next  = wait_cnt_reg;
        fetch_err_next = fetch_err_reg;
`ifdef IFU_MISALIGN_TRAP_EN
        trap_next      = trap_reg;
`endif
        case (state_reg)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (IMEM_Ack_i) begin
                    // An ack in the final allowed cycle still wins over timeout
                    instr_next    = IMEM_Data_i;
                    valid_next    = 1'b1;
                    wait_cnt_next = '0;
                    state_next    = VALID;
                end else if (TIMEOUT_EN && (wait_cnt_reg == TIMEOUT_LAST)) begin
                    fetch_err_next = 1'b1;
                    state_next     = HALT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            VALID: begin
                // Redirect is only meaningful on the accepting edge
                if (accept) begin
                    valid_next = 1'b0;
                    state_next = FETCH;
                    if (Redirect_i) begin
`ifdef IFU_MISALIGN_TRAP_EN
                        pc_next = Target_i;
                        if (Target_i[1:0] != 2'b00) begin
                            trap_next  = 1'b1;
                            state_next = HALT;
                        end
`else
                        pc_next = Target_i & ~32'h3;
`endif
                    end else begin
                        pc_next = pc_reg + 32'd4;
                    end
                end
            end
            HALT: begin
                // Frozen until reset
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign IMEM_Req_o    = (state_reg == FETCH);
    assign IMEM_Addr_o   = pc_reg;
    assign PC_o          = pc_reg;
    assign PC_Plus_4_o   = pc_reg + 32'd4;
    assign Instr_o       = instr_reg;
    assign Instr_Valid_o = valid_reg;
    // 7'h00 is a bubble for the decoder
    assign Opcode_o      = valid_reg ? instr_reg[6:0] : 7'h00;
    assign Fetch_Err_o   = fetch_err_reg;
`ifdef IFU_MISALIGN_TRAP_EN
    assign Trap_o        = trap_reg;
`else
    assign Trap_o        = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
//   Directed bench for instruction_fetch_unit (TIMEOUT_CYCLES=4).
//   Expectations for misaligned redirects follow IFU_MISALIGN_TRAP_EN.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        redirect;
    logic [31:0] target;
    logic        fetch_err;
    logic        trap;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        auto_mem = 1'b0;
    logic [31:0] data_word = 32'h0020_81B3;

    instruction_fetch_unit #(
        .RESET_PC       (32'h0040_0000),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .IMEM_Req_o    (imem_req),
        .IMEM_Addr_o   (imem_addr),
        .IMEM_Ack_i    (imem_ack),
        .IMEM_Data_i   (imem_data),
        .Instr_o       (instr),
        .Opcode_o      (opcode),
        .Instr_Valid_o (instr_valid),
        .Instr_Ready_i (instr_ready),
        .PC_o          (pc),
        .PC_Plus_4_o   (pc_plus_4),
        .Redirect_i    (redirect),
        .Target_i      (target),
        .Fetch_Err_o   (fetch_err),
        .Trap_o        (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance one clock; sample point is 1ns after the edge. In auto mode
    // the memory acks in the same cycle it sees a request (zero wait).
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_mem) begin
            imem_ack  = imem_req;
            imem_data = data_word;
        end
    endtask

    initial begin
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_data   = 32'h0;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        target      = 32'h0;

        // ---- reset values ----
        #2 reset = 1'b0;
        #1;
        check("rst_req",   imem_req,    0);
        check("rst_valid", instr_valid, 0);
        check("rst_pc",    pc,          32'h0040_0000);
        check("rst_pc4",   pc_plus_4,   32'h0040_0004);
        check("rst_instr", instr,       0);
        check("rst_op",    opcode,      0);
        check("rst_err",   fetch_err,   0);
        check("rst_trap",  trap,        0);
        tick();
        check("rst_hold_req", imem_req, 0);
        reset    = 1'b1;
        auto_mem = 1'b1;

        // ---- T1/T2: release then zero-wait streaming ----
        tick();
        check("rel_req",  imem_req,  1);
        check("rel_addr", imem_addr, 32'h0040_0000);
        tick();
        check("s0_valid", instr_valid, 1);
        check("s0_instr", instr,       32'h0020_81B3);
        check("s0_op",    opcode,      7'h33);
        check("s0_req",   imem_req,    0);
        tick();
        check("s1_valid", instr_valid, 0);
        check("s1_op",    opcode,      0);
        check("s1_addr",  imem_addr,   32'h0040_0004);
        tick();
        check("s1_pc",    pc,          32'h0040_0004);
        check("s1_vld",   instr_valid, 1);
        tick();
        check("s2_addr",  imem_addr,   32'h0040_0008);
        tick();
        check("s2_vld",   instr_valid, 1);
        check("s2_pc4",   pc_plus_4,   32'h0040_000C);

        // ---- T3: backpressure, late ack/data must be ignored ----
        instr_ready = 1'b0;
        auto_mem    = 1'b0;
        imem_ack    = 1'b1;
        imem_data   = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp%0d_vld", i), instr_valid, 1);
            check($sformatf("bp%0d_pc", i),  pc,          32'h0040_0008);
            check($sformatf("bp%0d_ins", i), instr,       32'h0020_81B3);
            check($sformatf("bp%0d_req", i), imem_req,    0);
        end
        imem_ack    = 1'b0;
        auto_mem    = 1'b1;
        instr_ready = 1'b1;
        tick();
        check("bp_adv_addr", imem_addr, 32'h0040_000C);
        check("bp_adv_req",  imem_req,  1);
        tick();
        check("bp_adv_vld",  instr_valid, 1);

        // ---- T4: redirect ignored without ready, taken on accept ----
        instr_ready = 1'b0;
        redirect    = 1'b1;
        target      = 32'h0040_0100;
        tick();
        check("rd_ign_pc",  pc,          32'h0040_000C);
        check("rd_ign_vld", instr_valid, 1);
        instr_ready = 1'b1;
        tick();
        redirect = 1'b0;
        check("rd_addr", imem_addr, 32'h0040_0100);
        check("rd_req",  imem_req,  1);
        tick();
        check("rd_vld",  instr_valid, 1);

        // ---- T6: misaligned redirect ----
        redirect = 1'b1;
        target   = 32'h0040_0102;
        tick();
        redirect = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
        check("mis_trap", trap,      1);
        check("mis_pc",   pc,        32'h0040_0102);
        check("mis_req",  imem_req,  0);
        tick();
        check("mis_halt_req", imem_req, 0);
`else
        check("mis_addr", imem_addr, 32'h0040_0100);
        check("mis_trap", trap,      0);
        check("mis_req",  imem_req,  1);
`endif

        // ---- T1: asynchronous reset in the middle of a cycle ----
        auto_mem = 1'b0;
        imem_ack = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("arst_req",   imem_req,    0);
        check("arst_valid", instr_valid, 0);
        check("arst_pc",    pc,          32'h0040_0000);
        check("arst_trap",  trap,        0);
        check("arst_instr", instr,       0);
        tick();
        reset = 1'b1;
        tick();
        check("arel_req", imem_req, 1);

        // ---- T5a: ack in the 4th request cycle beats the timeout ----
        tick();
        tick();
        tick();
        check("to_c4_req", imem_req, 1);
        imem_ack  = 1'b1;
        imem_data = 32'h0000_0013;
        tick();
        imem_ack = 1'b0;
        check("to_ack_err", fetch_err,   0);
        check("to_ack_vld", instr_valid, 1);
        check("to_ack_op",  opcode,      7'h13);

        // ---- T5b: no ack for 4 request cycles -> HALT ----
        tick();
        check("to_c1_req", imem_req,  1);
        check("to_c1_pc",  pc,        32'h0040_0004);
        tick();
        tick();
        tick();
        check("to_c4b_req", imem_req,  1);
        check("to_c4b_err", fetch_err, 0);
        tick();
        check("halt_err", fetch_err,   1);
        check("halt_req", imem_req,    0);
        check("halt_vld", instr_valid, 0);
        check("halt_pc",  pc,          32'h0040_0004);
        imem_ack = 1'b1;
        tick();
        tick();
        imem_ack = 1'b0;
        check("halt_stay_req", imem_req,  0);
        check("halt_stay_err", fetch_err, 1);
        check("halt_stay_vld", instr_valid, 0);

        // ---- PC+4 wraps at the top of the address space ----
        #2 reset = 1'b0;
        #1;
        check("wrst_err", fetch_err, 0);
        tick();
        reset    = 1'b1;
        auto_mem = 1'b1;
        tick();
        tick();
        check("w_vld", instr_valid, 1);
        redirect = 1'b1;
        target   = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check("w_addr", imem_addr, 32'hFFFF_FFFC);
        check("w_pc4",  pc_plus_4, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
